// File: rtl/divider_shift_pkg.sv
// Shared definitions for the power-of-two divider: rounding modes, default
// widths and the rounding-increment decision used by every lane.
package divider_shift_pkg;

  localparam int DEF_LANES     = 4;
  localparam int DEF_DW        = 16;
  localparam int DEF_OW        = 16;
  localparam int DEF_MAX_SHIFT = 15;

  typedef enum logic [1:0] {
    MODE_FLOOR     = 2'd0,
    MODE_HALF_AWAY = 2'd1,
    MODE_HALF_EVEN = 2'd2,
    MODE_TRUNC     = 2'd3
  } mode_e;

  // The floor quotient is already available; each mode only decides whether
  // to add one, from the dropped fraction (guard/sticky), sign and result LSB.
  function automatic logic round_inc(input mode_e mode, input logic sign,
                                     input logic guard, input logic sticky,
                                     input logic lsb);
    logic inc;
    inc = 1'b0;
    case (mode)
      MODE_FLOOR:     inc = 1'b0;
      MODE_HALF_AWAY: inc = guard & (~sign | sticky);
      MODE_HALF_EVEN: inc = guard & (sticky | lsb);
      MODE_TRUNC:     inc = sign & (guard | sticky);
      default:        inc = 1'b0;
    endcase
    return inc;
  endfunction

endpackage

// File: rtl/divider_shift_lane.sv
// One lane of the divider: S1 operand capture, S2 arithmetic shift with
// guard/sticky extraction, S3 rounding increment and output saturation.
module divider_shift_lane
  import divider_shift_pkg::*;
#(
  parameter int DW      = DEF_DW,
  parameter int OW      = DEF_OW,
  parameter int SHIFT_W = 4
) (
  input  logic               i_Sys_clk,
  input  logic               i_Rst_n,
  input  logic               i_Ld1,
  input  logic               i_Ld2,
  input  logic               i_Ld3,
  input  logic [DW-1:0]      i_Numer,
  input  logic [SHIFT_W-1:0] i_Shift,
  input  mode_e              i_Mode,
  output logic [OW-1:0]      o_Quotient,
  output logic               o_Sat
);

  localparam logic signed [DW:0] OMAX_W = {{(DW + 2 - OW){1'b0}}, {(OW - 1){1'b1}}};
  localparam logic signed [DW:0] OMIN_W = {{(DW + 2 - OW){1'b1}}, {(OW - 1){1'b0}}};

  logic [DW-1:0]      x_s1;
  logic [DW-1:0]      guard_bit;
  logic signed [DW:0] floor_d;
  logic signed [DW:0] floor_s2;
  logic signed [DW:0] rnd;
  logic               guard_d, sticky_d;
  logic               guard_s2, sticky_s2, sign_s2;
  logic               inc;

  // NOTE: the S1/S2 data registers have no reset; the valid bits in the top
  // decide whether their contents mean anything, so only S3 outputs reset.
  always_ff @(posedge i_Sys_clk) begin
    if (i_Ld1) x_s1 <= i_Numer;
    if (i_Ld2) begin
      floor_s2  <= floor_d;
      guard_s2  <= guard_d;
      sticky_s2 <= sticky_d;
      sign_s2   <= x_s1[DW-1];
    end
  end

  // One extra bit of headroom so the later +1 cannot wrap.
  always_comb begin
    floor_d   = $signed({x_s1[DW-1], x_s1}) >>> i_Shift;
    guard_bit = DW'(1) << (i_Shift - SHIFT_W'(1));
    guard_d   = 1'b0;
    sticky_d  = 1'b0;
    if (i_Shift != '0) begin
      guard_d  = |(x_s1 & guard_bit);
      sticky_d = |(x_s1 & (guard_bit - DW'(1)));
    end
  end

  always_comb begin
    inc = round_inc(i_Mode, sign_s2, guard_s2, sticky_s2, floor_s2[0]);
    rnd = floor_s2 + $signed({{DW{1'b0}}, inc});
  end

  always_ff @(posedge i_Sys_clk or negedge i_Rst_n) begin
    if (!i_Rst_n) begin
      o_Quotient <= '0;
      o_Sat      <= 1'b0;
    end else if (i_Ld3) begin
      if (rnd > OMAX_W) begin
        o_Quotient <= OMAX_W[OW-1:0];
        o_Sat      <= 1'b1;
      end else if (rnd < OMIN_W) begin
        o_Quotient <= OMIN_W[OW-1:0];
        o_Sat      <= 1'b1;
      end else begin
        o_Quotient <= rnd[OW-1:0];
        o_Sat      <= 1'b0;
      end
    end
  end

endmodule

// File: rtl/divider_shift_round.sv
// Multi-lane signed divide-by-2^s with selectable rounding and saturation,
// behind a 3-stage valid/ready pipeline that fully honours backpressure.
module divider_shift_round
  import divider_shift_pkg::*;
#(
  parameter int LANES     = DEF_LANES,
  parameter int DW        = DEF_DW,
  parameter int OW        = DEF_OW,
  parameter int MAX_SHIFT = DEF_MAX_SHIFT,
  parameter int SHIFT_W   = $clog2(MAX_SHIFT + 1)
) (
  input  logic                i_Sys_clk,
  input  logic                i_Rst_n,
  input  logic                i_Valid,
  output logic                o_Ready,
  input  logic [LANES*DW-1:0] i_Numer,
  input  logic [SHIFT_W-1:0]  i_Shift,
  input  logic [1:0]          i_Mode,
  output logic                o_Valid,
  input  logic                i_Ready,
  output logic [LANES*OW-1:0] o_Quotient,
  output logic [LANES-1:0]    o_Sat
);

  logic               v1, v2, v3;
  logic               ld1, ld2, ld3;
  logic [SHIFT_W-1:0] shift_clamped;
  logic [SHIFT_W-1:0] shift_s1;
  mode_e              mode_s1, mode_s2;

  // A stage loads when it is empty or its successor is loading; ready never
  // looks at i_Valid, so upstream cannot form a combinational loop through us.
  always_comb begin
    ld3           = ~v3 | i_Ready;
    ld2           = ~v2 | ld3;
    ld1           = ~v1 | ld2;
    o_Ready       = ld1;
    o_Valid       = v3;
    shift_clamped = (i_Shift > SHIFT_W'(MAX_SHIFT)) ? SHIFT_W'(MAX_SHIFT) : i_Shift;
  end

  always_ff @(posedge i_Sys_clk or negedge i_Rst_n) begin
    if (!i_Rst_n) begin
      v1 <= 1'b0;
      v2 <= 1'b0;
      v3 <= 1'b0;
    end else begin
      if (ld1) v1 <= i_Valid;
      if (ld2) v2 <= v1;
      if (ld3) v3 <= v2;
    end
  end

  // Shift is consumed in S2 and mode in S3, so each is carried only that far.
  always_ff @(posedge i_Sys_clk) begin
    if (ld1) begin
      shift_s1 <= shift_clamped;
      mode_s1  <= mode_e'(i_Mode);
    end
    if (ld2) mode_s2 <= mode_s1;
  end

  for (genvar k = 0; k < LANES; k++) begin : g_lane
    divider_shift_lane #(
      .DW      (DW),
      .OW      (OW),
      .SHIFT_W (SHIFT_W)
    ) u_lane (
      .i_Sys_clk  (i_Sys_clk),
      .i_Rst_n    (i_Rst_n),
      .i_Ld1      (ld1),
      .i_Ld2      (ld2),
      .i_Ld3      (ld3),
      .i_Numer    (i_Numer[k*DW +: DW]),
      .i_Shift    (shift_s1),
      .i_Mode     (mode_s2),
      .o_Quotient (o_Quotient[k*OW +: OW]),
      .o_Sat      (o_Sat[k])
    );
  end

endmodule

// File: tb/tb_divider_shift_round.sv
// Directed and stall-stress bench for divider_shift_round: a default unit,
// an 8-bit-output unit and a MAX_SHIFT=12 unit share one stimulus stream.
module tb_divider_shift_round;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        valid, rdy;
  logic [63:0] numer;
  logic [3:0]  shift;
  logic [1:0]  mode;

  logic        ordy0, ov0, ordy8, ov8, ordyc, ovc;
  logic [63:0] oq0, oqc;
  logic [31:0] oq8;
  logic [3:0]  sat0, sat8, satc;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  divider_shift_round u_dut (
    .i_Sys_clk(clk), .i_Rst_n(rst_n), .i_Valid(valid), .o_Ready(ordy0),
    .i_Numer(numer), .i_Shift(shift), .i_Mode(mode), .o_Valid(ov0),
    .i_Ready(rdy), .o_Quotient(oq0), .o_Sat(sat0));

  divider_shift_round #(.OW(8)) u_dut8 (
    .i_Sys_clk(clk), .i_Rst_n(rst_n), .i_Valid(valid), .o_Ready(ordy8),
    .i_Numer(numer), .i_Shift(shift), .i_Mode(mode), .o_Valid(ov8),
    .i_Ready(rdy), .o_Quotient(oq8), .o_Sat(sat8));

  divider_shift_round #(.MAX_SHIFT(12)) u_dutc (
    .i_Sys_clk(clk), .i_Rst_n(rst_n), .i_Valid(valid), .o_Ready(ordyc),
    .i_Numer(numer), .i_Shift(shift), .i_Mode(mode), .o_Valid(ovc),
    .i_Ready(rdy), .o_Quotient(oqc), .o_Sat(satc));

  function automatic logic [63:0] p16(input int a0, input int a1, input int a2, input int a3);
    return {16'(a3), 16'(a2), 16'(a1), 16'(a0)};
  endfunction

  function automatic logic [31:0] p8(input int a0, input int a1, input int a2, input int a3);
    return {8'(a3), 8'(a2), 8'(a1), 8'(a0)};
  endfunction

  // Reference: exact floor division plus remainder comparison against half.
  function automatic longint model(input longint x, input int s, input int m,
                                   input int ow, output logic sat);
    longint p, fl, r, half, q, hi, lo;
    p    = longint'(1) << s;
    fl   = x >>> s;
    r    = x - fl * p;
    half = p >>> 1;
    q    = fl;
    if (s > 0) begin
      case (m)
        1: if (r > half || (r == half && x >= 0)) q = fl + 1;
        2: if (r > half || (r == half && fl[0])) q = fl + 1;
        3: if (x < 0 && r != 0) q = fl + 1;
        default: q = fl;
      endcase
    end
    hi  = (longint'(1) << (ow - 1)) - 1;
    lo  = -(longint'(1) << (ow - 1));
    sat = 1'b0;
    if (q > hi) begin q = hi; sat = 1'b1; end
    if (q < lo) begin q = lo; sat = 1'b1; end
    return q;
  endfunction

  function automatic void model4(input logic [63:0] n, input int s, input int m,
                                 output logic [63:0] q, output logic [3:0] sat);
    int se;
    longint x, r;
    logic st;
    se  = (s > 15) ? 15 : s;
    q   = '0;
    sat = '0;
    for (int k = 0; k < 4; k++) begin
      x = longint'($signed(n[k*16 +: 16]));
      r = model(x, se, m, 16, st);
      q[k*16 +: 16] = 16'(r);
      sat[k] = st;
    end
  endfunction

  task automatic do_reset;
    rst_n = 1'b0; valid = 1'b0; rdy = 1'b1; numer = '0; shift = '0; mode = '0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic drain;
    valid = 1'b0; rdy = 1'b1;
    repeat (4) @(negedge clk);
  endtask

  // Single transaction into an empty pipe; returns at the negedge where o_Valid is seen.
  task automatic xfer(input logic [63:0] n, input logic [3:0] s, input logic [1:0] m,
                      input string name);
    int cnt;
    valid = 1'b1; numer = n; shift = s; mode = m; rdy = 1'b1;
    cnt = 0;
    do begin
      @(negedge clk);
      valid = 1'b0;
      cnt++;
    end while (!ov0 && cnt < 10);
    checks++;
    if (cnt != 3) begin
      errors++;
      $display("FAIL %s latency: got %0d cycles, expected 3", name, cnt);
    end
  endtask

  task automatic test_reset;
    checks++;
    if ({ov0, ordy0, sat0, oq0} !== {1'b0, 1'b1, 4'h0, 64'h0}) begin
      errors++;
      $display("FAIL reset_state: ov=%b rdy=%b sat=%h q=%h, expected 0 1 0 0", ov0, ordy0, sat0, oq0);
    end
    checks++;
    if ({ov8, ordy8, sat8, oq8} !== {1'b0, 1'b1, 4'h0, 32'h0}) begin
      errors++;
      $display("FAIL reset_state_ow8: ov=%b rdy=%b sat=%h q=%h, expected 0 1 0 0", ov8, ordy8, sat8, oq8);
    end
  endtask

  task automatic test_modes;
    logic [63:0] e [4];
    e[0] = p16(1, -2, 2, -2);
    e[1] = p16(1, -1, 3, -2);
    e[2] = p16(1, -1, 2, -2);
    e[3] = p16(1, -1, 2, -1);
    for (int m = 0; m < 4; m++) begin
      xfer(p16(5, -5, 10, -6), 4'd2, 2'(m), "modes");
      checks++;
      if (oq0 !== e[m] || sat0 !== 4'h0) begin
        errors++;
        $display("FAIL modes m=%0d: got q=%h sat=%h, expected q=%h sat=0", m, oq0, sat0, e[m]);
      end
    end
  endtask

  task automatic test_shift_zero;
    logic [63:0] n;
    n = p16(32767, -32768, 0, -1);
    for (int m = 0; m < 4; m++) begin
      xfer(n, 4'd0, 2'(m), "shift_zero");
      checks++;
      if (oq0 !== n || sat0 !== 4'h0) begin
        errors++;
        $display("FAIL shift_zero m=%0d: got q=%h sat=%h, expected q=%h sat=0", m, oq0, sat0, n);
      end
    end
  endtask

  task automatic test_clamp;
    logic [63:0] n, e0 [2], ec [2];
    n     = p16(-32768, 32767, 2048, -2049);
    e0[0] = p16(-1, 0, 0, -1);
    e0[1] = p16(-1, 1, 0, 0);
    ec[0] = p16(-8, 7, 0, -1);
    ec[1] = p16(-8, 8, 1, -1);
    for (int m = 0; m < 2; m++) begin
      xfer(n, 4'd15, 2'(m), "clamp");
      checks++;
      if (oq0 !== e0[m]) begin
        errors++;
        $display("FAIL max_shift m=%0d: got %h, expected %h", m, oq0, e0[m]);
      end
      checks++;
      if (oqc !== ec[m] || satc !== 4'h0) begin
        errors++;
        $display("FAIL shift_clamp m=%0d: got q=%h sat=%h, expected q=%h sat=0", m, oqc, satc, ec[m]);
      end
    end
  endtask

  task automatic test_saturation;
    xfer(p16(1000, -1000, 254, 255), 4'd1, 2'd1, "saturation");
    checks++;
    if (oq8 !== p8(127, -128, 127, 127) || sat8 !== 4'b1011) begin
      errors++;
      $display("FAIL sat_ow8: got q=%h sat=%b, expected q=%h sat=1011", oq8, sat8, p8(127, -128, 127, 127));
    end
    checks++;
    if (oq0 !== p16(500, -500, 127, 128) || sat0 !== 4'h0) begin
      errors++;
      $display("FAIL sat_ow16: got q=%h sat=%b, expected q=%h sat=0000", oq0, sat0, p16(500, -500, 127, 128));
    end
    xfer(p16(32767, -32768, -32767, 3), 4'd1, 2'd1, "headroom");
    checks++;
    if (oq0 !== p16(16384, -16384, -16384, 2) || sat0 !== 4'h0) begin
      errors++;
      $display("FAIL headroom: got q=%h sat=%b, expected q=%h sat=0000", oq0, sat0, p16(16384, -16384, -16384, 2));
    end
    checks++;
    if (oq8 !== p8(127, -128, -128, 2) || sat8 !== 4'b0111) begin
      errors++;
      $display("FAIL headroom_ow8: got q=%h sat=%b, expected q=%h sat=0111", oq8, sat8, p8(127, -128, -128, 2));
    end
  endtask

  task automatic test_back_to_back;
    logic [63:0] n [8], eq [8];
    logic [3:0]  es [8], sh [8];
    logic [1:0]  md [8];
    drain();
    for (int i = 0; i < 8; i++) begin
      n[i]  = {$urandom, $urandom};
      sh[i] = 4'((i * 5 + 3) % 16);
      md[i] = 2'(i % 4);
      model4(n[i], int'(sh[i]), int'(md[i]), eq[i], es[i]);
    end
    for (int c = 0; c < 14; c++) begin
      valid = (c < 8);
      if (c < 8) begin numer = n[c]; shift = sh[c]; mode = md[c]; end
      rdy = 1'b1;
      #1;
      checks++;
      if (ov0 !== (c >= 3 && c < 11)) begin
        errors++;
        $display("FAIL b2b_valid c=%0d: got %b, expected %b", c, ov0, (c >= 3 && c < 11));
      end else if (ov0) begin
        checks++;
        if (oq0 !== eq[c-3] || sat0 !== es[c-3]) begin
          errors++;
          $display("FAIL b2b_data c=%0d: got q=%h sat=%b, expected q=%h sat=%b", c, oq0, sat0, eq[c-3], es[c-3]);
        end
      end
      @(negedge clk);
    end
  endtask

  task automatic test_stall_random;
    logic [63:0] q_exp [$];
    logic [3:0]  s_exp [$];
    logic [63:0] pn, held_q, mq;
    logic [3:0]  ps, held_s, ms;
    logic [1:0]  pm;
    logic        pend, stalled;
    int          sent, got, inflight, cyc;
    drain();
    pend = 1'b0; stalled = 1'b0; sent = 0; got = 0; inflight = 0; cyc = 0;
    pn = '0; ps = '0; pm = '0; held_q = '0; held_s = '0;
    while (got < 100 && cyc < 3000) begin
      if (!pend && sent < 100) begin
        pn   = {$urandom, $urandom};
        ps   = 4'($urandom_range(0, 15));
        pm   = 2'($urandom_range(0, 3));
        pend = 1'b1;
      end
      valid = pend; numer = pn; shift = ps; mode = pm;
      rdy   = 1'($urandom_range(0, 1));
      #1;
      if (stalled) begin
        checks++;
        if (ov0 !== 1'b1 || oq0 !== held_q || sat0 !== held_s) begin
          errors++;
          $display("FAIL stall_hold cyc=%0d: got v=%b q=%h sat=%b, expected v=1 q=%h sat=%b", cyc, ov0, oq0, sat0, held_q, held_s);
        end
      end
      checks++;
      if (ordy0 !== ((inflight != 3) || rdy)) begin
        errors++;
        $display("FAIL stall_ready cyc=%0d: got %b, expected %b (inflight %0d)", cyc, ordy0, ((inflight != 3) || rdy), inflight);
      end
      if (ov0 === 1'b1 && rdy) begin
        checks++;
        if (q_exp.size() == 0) begin
          errors++;
          $display("FAIL stall_extra cyc=%0d: got unexpected output q=%h", cyc, oq0);
        end else begin
          mq = q_exp.pop_front();
          ms = s_exp.pop_front();
          if (oq0 !== mq || sat0 !== ms) begin
            errors++;
            $display("FAIL stall_data #%0d: got q=%h sat=%b, expected q=%h sat=%b", got, oq0, sat0, mq, ms);
          end
        end
        got++;
      end
      stalled = (ov0 === 1'b1) && !rdy;
      held_q  = oq0;
      held_s  = sat0;
      if (valid && ordy0) begin
        model4(pn, int'(ps), int'(pm), mq, ms);
        q_exp.push_back(mq);
        s_exp.push_back(ms);
        sent++;
        pend = 1'b0;
      end
      inflight = sent - got;
      @(negedge clk);
      cyc++;
    end
    valid = 1'b0;
    checks++;
    if (got != 100) begin
      errors++;
      $display("FAIL stall_timeout: got %0d results, expected 100", got);
    end
  endtask

  task automatic test_reset_midstream;
    logic stale;
    drain();
    rdy = 1'b0; valid = 1'b1; numer = p16(100, 200, 300, 400); shift = 4'd1; mode = 2'd0;
    repeat (4) @(negedge clk);
    #1;
    checks++;
    if (ov0 !== 1'b1 || ordy0 !== 1'b0 || oq0 !== p16(50, 100, 150, 200)) begin
      errors++;
      $display("FAIL rst_full: got v=%b rdy=%b q=%h, expected v=1 rdy=0 q=%h", ov0, ordy0, oq0, p16(50, 100, 150, 200));
    end
    #1;
    rst_n = 1'b0;
    valid = 1'b0;
    #1;
    checks++;
    if ({ov0, sat0, oq0} !== {1'b0, 4'h0, 64'h0}) begin
      errors++;
      $display("FAIL rst_async: got v=%b sat=%b q=%h, expected all 0", ov0, sat0, oq0);
    end
    @(negedge clk);
    rst_n = 1'b1;
    rdy   = 1'b1;
    #1;
    checks++;
    if (ordy0 !== 1'b1) begin
      errors++;
      $display("FAIL rst_ready: got %b, expected 1", ordy0);
    end
    stale = 1'b0;
    repeat (6) begin
      @(negedge clk);
      if (ov0 !== 1'b0) stale = 1'b1;
    end
    checks++;
    if (stale) begin
      errors++;
      $display("FAIL rst_stale: got o_Valid after reset, expected none");
    end
  endtask

  initial begin
    do_reset();
    test_reset();
    test_modes();
    test_shift_zero();
    test_clamp();
    test_saturation();
    test_back_to_back();
    test_stall_random();
    test_reset_midstream();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not complete in time");
    $fatal(1, "watchdog expired");
  end

endmodule
